// File: rtl/uart_rx_fifo_p_if.sv
// Handshake bundle between the UART receiver/host side and the receive FIFO.
// The master side drives the receiver flag and read requests; the slave is the FIFO.
interface uart_rx_fifo_p_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              rx_enbl;
  logic              flag;
  logic [DATA_W-1:0] dout;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [AW:0]       count;
  logic              overflow;
  logic              ovf_clr;
  logic [7:0]        drop_cnt;

  modport master (
    output rx_enbl, flag, dout, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, almost_full, count, overflow, drop_cnt
  );

  modport slave (
    input  rx_enbl, flag, dout, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, almost_full, count, overflow, drop_cnt
  );
endinterface

// File: rtl/uart_rx_fifo_p.sv
// Receive FIFO between the UART receiver and the host read port: one write per flag
// rising edge, registered 1-cycle read, selectable overwrite/drop policy when full.
module uart_rx_fifo_p #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int OVF_MODE = 1,
  parameter int AF_LEVEL = 12
) (
  input  logic             clk,
  input  logic             areset,
  uart_rx_fifo_p_if.slave  bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C      = (AW+1)'(AF_LEVEL);
  localparam logic        OVERWRITE = (OVF_MODE != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              flag_q, flag_d;
  logic              arm_q, arm_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic is_full, is_empty;
  logic wr_evt, pop, ovf_evt, discard, do_write;

  always_comb begin
    is_full  = (count_q == DEPTH_C);
    is_empty = (count_q == '0);

    // arm_q stays low for the first clock after reset so a flag that is already
    // high at release is absorbed into flag_q instead of looking like an edge.
    flag_d   = bus.flag;
    arm_d    = 1'b1;
    wr_evt   = arm_q & bus.rx_enbl & bus.flag & ~flag_q;

    pop      = bus.rd_en & ~is_empty;
    ovf_evt  = wr_evt & is_full & ~pop;
    discard  = ovf_evt & OVERWRITE;
    do_write = wr_evt & (~is_full | pop | OVERWRITE);

    wr_ptr_d = do_write        ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = (pop | discard) ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (do_write && !discard && !pop)  count_d = count_q + (AW+1)'(1);
    else if (pop && !do_write)         count_d = count_q - (AW+1)'(1);

    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop;

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (ovf_evt) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flag_q     <= 1'b0;
      arm_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flag_q     <= flag_d;
      arm_q      <= arm_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage has no reset; every entry is written before count lets it be read,
  // and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= bus.dout;
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= AF_C);
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo_p.sv
// Directed bench: two FIFOs (overwrite and drop policy) share one stimulus stream.
module tb_uart_rx_fifo_p;
  logic       clk = 1'b0;
  logic       areset;
  logic       rx_enbl, flag, rd_en, ovf_clr;
  logic [7:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fifo_p_if #(.DATA_W(8), .DEPTH(16)) ifa ();
  uart_rx_fifo_p_if #(.DATA_W(8), .DEPTH(16)) ifb ();

  assign ifa.rx_enbl = rx_enbl;
  assign ifa.flag    = flag;
  assign ifa.dout    = dout;
  assign ifa.rd_en   = rd_en;
  assign ifa.ovf_clr = ovf_clr;
  assign ifb.rx_enbl = rx_enbl;
  assign ifb.flag    = flag;
  assign ifb.dout    = dout;
  assign ifb.rd_en   = rd_en;
  assign ifb.ovf_clr = ovf_clr;

  uart_rx_fifo_p #(.DATA_W(8), .DEPTH(16), .OVF_MODE(1), .AF_LEVEL(12)) dut_a (
    .clk(clk), .areset(areset), .bus(ifa)
  );
  uart_rx_fifo_p #(.DATA_W(8), .DEPTH(16), .OVF_MODE(0), .AF_LEVEL(12)) dut_b (
    .clk(clk), .areset(areset), .bus(ifb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d);
    dout = d;
    flag = 1'b1;
    step();
    flag = 1'b0;
    step();
  endtask

  initial begin
    areset  = 1'b1;
    rx_enbl = 1'b1;
    flag    = 1'b1;
    dout    = 8'h00;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;

    #12;
    check("rst_count",    32'(ifa.count),       32'd0);
    check("rst_empty",    32'(ifa.empty),       32'd1);
    check("rst_full",     32'(ifa.full),        32'd0);
    check("rst_af",       32'(ifa.almost_full), 32'd0);
    check("rst_rd_valid", 32'(ifa.rd_valid),    32'd0);
    check("rst_rd_data",  32'(ifa.rd_data),     32'd0);
    check("rst_overflow", 32'(ifa.overflow),    32'd0);
    check("rst_drop",     32'(ifa.drop_cnt),    32'd0);
    check("rst_b_empty",  32'(ifb.empty),       32'd1);

    // flag already high when reset releases must not write
    areset = 1'b0;
    step(); step(); step();
    flag = 1'b0;
    step();
    check("flag_high_at_release", 32'(ifa.count), 32'd0);

    pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
    check("four_count", 32'(ifa.count), 32'd4);
    check("four_empty", 32'(ifa.empty), 32'd0);

    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("four_rd_data",  32'(ifa.rd_data),  32'(8'h11 * (i + 1)));
      check("four_rd_valid", 32'(ifa.rd_valid), 32'd1);
    end
    rd_en = 1'b0;
    step();
    check("four_rd_valid_off", 32'(ifa.rd_valid), 32'd0);
    check("four_drained",      32'(ifa.empty),    32'd1);

    // long flag pulse stores exactly once
    dout = 8'hA5;
    flag = 1'b1;
    repeat (10) step();
    flag = 1'b0;
    step();
    check("long_flag_count_a", 32'(ifa.count), 32'd1);
    check("long_flag_count_b", 32'(ifb.count), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("long_flag_data", 32'(ifa.rd_data), 32'h A5);
    step();

    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("underflow_rd_valid", 32'(ifa.rd_valid), 32'd0);
    check("underflow_rd_data",  32'(ifa.rd_data),  32'hA5);
    check("underflow_count",    32'(ifa.count),    32'd0);

    rx_enbl = 1'b0;
    pulse(8'h01); pulse(8'h02); pulse(8'h03);
    check("disabled_count", 32'(ifa.count), 32'd0);
    rx_enbl = 1'b1;

    for (int i = 0; i < 16; i++) begin
      pulse(8'(i));
      if (i == 10) check("af_at_11", 32'(ifa.almost_full), 32'd0);
      if (i == 11) check("af_at_12", 32'(ifa.almost_full), 32'd1);
    end
    check("fill_count", 32'(ifa.count), 32'd16);
    check("fill_full",  32'(ifa.full),  32'd1);
    check("fill_b",     32'(ifb.count), 32'd16);

    pulse(8'hF0);
    check("ovw_count",    32'(ifa.count),    32'd16);
    check("ovw_overflow", 32'(ifa.overflow), 32'd1);
    check("ovw_drop",     32'(ifa.drop_cnt), 32'd1);
    check("drp_count",    32'(ifb.count),    32'd16);
    check("drp_overflow", 32'(ifb.overflow), 32'd1);
    check("drp_drop",     32'(ifb.drop_cnt), 32'd1);

    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) begin
        check("ovw_first", 32'(ifa.rd_data), 32'h01);
        check("drp_first", 32'(ifb.rd_data), 32'h00);
      end
      if (i == 15) begin
        check("ovw_last", 32'(ifa.rd_data), 32'hF0);
        check("drp_last", 32'(ifb.rd_data), 32'h0F);
      end
    end
    rd_en = 1'b0;
    step();
    check("ovw_drained", 32'(ifa.empty), 32'd1);
    check("drp_drained", 32'(ifb.empty), 32'd1);

    for (int i = 0; i < 16; i++) pulse(8'(i));
    repeat (260) pulse(8'hEE);
    check("sat_drop_a", 32'(ifa.drop_cnt), 32'd255);
    check("sat_drop_b", 32'(ifb.drop_cnt), 32'd255);

    // clear wins over a same-cycle overflow
    dout    = 8'hEE;
    flag    = 1'b1;
    ovf_clr = 1'b1;
    step();
    flag    = 1'b0;
    ovf_clr = 1'b0;
    check("clr_overflow", 32'(ifa.overflow), 32'd0);
    check("clr_drop",     32'(ifa.drop_cnt), 32'd0);
    check("clr_drop_b",   32'(ifb.drop_cnt), 32'd0);
    step();

    dout  = 8'h77;
    flag  = 1'b1;
    rd_en = 1'b1;
    step();
    flag  = 1'b0;
    rd_en = 1'b0;
    check("full_rw_count",    32'(ifa.count),    32'd16);
    check("full_rw_overflow", 32'(ifa.overflow), 32'd0);
    check("full_rw_data_a",   32'(ifa.rd_data),  32'hEE);
    check("full_rw_data_b",   32'(ifb.rd_data),  32'h00);
    check("full_rw_valid",    32'(ifa.rd_valid), 32'd1);
    step();

    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 15) begin
        check("full_rw_last_a", 32'(ifa.rd_data), 32'h77);
        check("full_rw_last_b", 32'(ifb.rd_data), 32'h77);
      end
    end
    rd_en = 1'b0;
    step();
    check("full_rw_drained", 32'(ifa.empty), 32'd1);

    dout  = 8'h5C;
    flag  = 1'b1;
    rd_en = 1'b1;
    step();
    flag  = 1'b0;
    rd_en = 1'b0;
    check("empty_rw_valid", 32'(ifa.rd_valid), 32'd0);
    check("empty_rw_count", 32'(ifa.count),    32'd1);
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("empty_rw_data",     32'(ifa.rd_data),  32'h5C);
    check("empty_rw_valid_rd", 32'(ifa.rd_valid), 32'd1);
    step();

    pulse(8'h61); pulse(8'h62); pulse(8'h63); pulse(8'h64); pulse(8'h65);
    rd_en = 1'b1;
    step(); step();
    rd_en = 1'b0;
    check("burst_count", 32'(ifa.count), 32'd3);
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_count",    32'(ifa.count),       32'd0);
    check("mid_rst_empty",    32'(ifa.empty),       32'd1);
    check("mid_rst_full",     32'(ifa.full),        32'd0);
    check("mid_rst_af",       32'(ifa.almost_full), 32'd0);
    check("mid_rst_rd_valid", 32'(ifa.rd_valid),    32'd0);
    check("mid_rst_rd_data",  32'(ifa.rd_data),     32'd0);
    check("mid_rst_overflow", 32'(ifa.overflow),    32'd0);
    check("mid_rst_drop",     32'(ifa.drop_cnt),    32'd0);
    #2;
    areset = 1'b0;
    step();
    pulse(8'h99);
    check("post_rst_count", 32'(ifa.count), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_rst_data", 32'(ifa.rd_data), 32'h99);
    step();
    check("post_rst_empty", 32'(ifa.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
